uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
UART transmitter with a small write-side FIFO. It is the transmit counterpart to the team's UART receiver: 8N1 framing, LSB first, and the same bit period, 2604 clk per bit. Host logic pushes bytes with trmt. The block serialises them back-to-back on TX, so the host does not have to wait for each frame to finish. It sits between the command/response logic and the physical TX pin.

Parameters:
BAUD_DIV, 2604, clk cycles per bit period; must be >= 2.
DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
trmt  in  1  push request; pushes tx_data when full=0
tx_data  in  8  byte to push
TX  out  1  serial line; idles high
busy  out  1  high while a frame is on the line (XMIT state)
tx_done  out  1  one-cycle pulse at the end of each frame's stop bit
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
ovf  out  1  sticky; set by trmt while full; cleared only by reset

Behaviour:
- Reset values (async, rst_n=0): TX=1, busy=0, tx_done=0, full=0, empty=1, ovf=0. FIFO pointers, count and all counters are zeroed. State is IDLE.
- Reset mid-frame: TX returns to 1 immediately, the frame is abandoned, and the FIFO is flushed.
- FIFO:
  - trmt && !full writes tx_data at the clk edge.
  - trmt && full does not write, and sets ovf.
  - full blocks the write even when a pop happens in the same cycle.
  - A simultaneous push and pop with count in 1..DEPTH-1 leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Count width is clog2(DEPTH)+1.
- Frame register: 10 bits {1'b1 stop, data[7:0], 1'b0 start}. It shifts right, filling with 1. TX is driven from a flop equal to the frame register's bit 0.
- State machine (state_t: IDLE, XMIT):
  - IDLE, empty=1: TX=1, busy=0.
  - IDLE, empty=0: at the next edge, pop the head, load the frame register, reset baud_cnt and bit_cnt to 0, and go to XMIT. TX goes low from that edge, so latency is 2 edges from the trmt edge to the start bit when idle.
  - XMIT: baud_cnt counts 0..BAUD_DIV-1. At BAUD_DIV-1 it wraps to 0, the frame register shifts, and bit_cnt increments.
  - XMIT, bit_cnt==9 and baud_cnt==BAUD_DIV-1 (end of stop bit): pulse tx_done for that cycle.
    - If the FIFO is not empty, pop and load the next frame on the same edge, stay in XMIT, and clear bit_cnt. The next start bit follows the stop bit with no idle cycle.
    - Otherwise go to IDLE.
- Every bit lasts exactly BAUD_DIV cycles. A frame lasts exactly 10*BAUD_DIV cycles.
- A push during XMIT never disturbs the frame in flight.
- busy=1 exactly when state==XMIT.
- baud_cnt width is clog2(BAUD_DIV). bit_cnt is 4 bits.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic {IDLE, XMIT} tx_state_t
  - localparam UART_BAUD_DIV=2604 (shared with the receiver; half-period 1302 is used by the receiver)
  - localparam UART_FRAME_BITS=10
- One sub-module, uart_tx_fifo_buf: the synchronous DEPTH x 8 FIFO with push/pop/full/empty/count.
- The baud counter, bit counter, shifter and state machine stay in uart_tx_fifo.

Test Plan:
All tests use BAUD_DIV=16, DEPTH=4.
1. Single byte: push 0xA5 while idle. TX falls 2 edges after the trmt edge. TX bits, each 16 clk, are 0,1,0,1,0,0,1,0,1,1. tx_done pulses once at cycle 160 after the start bit began. busy then falls and TX stays 1.
2. Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles. Three contiguous frames appear with no idle gap, 480 cycles total. There are 3 tx_done pulses, each 160 cycles apart. empty=1 after the third load.
3. Overflow:
   - Push 6 bytes on consecutive cycles starting from idle. The first is popped after 1 cycle, so the FIFO holds 4 and full=1.
   - The 6th push is dropped and ovf=1 stays set.
   - Exactly 5 frames are sent, in order.
4. Push during frame: push 0x3C at mid-stop-bit of frame 0x81. 0x3C starts immediately after the stop bit, and frame 0x81 is intact.
5. Reset mid-frame: assert rst_n=0 at bit 4 of 0x5A with 2 bytes queued. TX goes to 1 asynchronously, and empty=1, busy=0, ovf=0. After release, no frame is sent without a new push.
6. Full plus pop at the same cycle: with count=4 and trmt high at the frame-end pop edge, the write is rejected, ovf is set, and count becomes 3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
//   tx_state_t      : transmitter state (IDLE / XMIT)
//   UART_BAUD_DIV   : clk cycles per bit period (receiver samples at half of it)
//   UART_FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
package uart_pkg;

    typedef enum logic {
        IDLE,
        XMIT
    } tx_state_t;

    localparam int unsigned UART_BAUD_DIV   = 2604;
    localparam int unsigned UART_FRAME_BITS = 10;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous DEPTH x WIDTH FIFO feeding the UART transmitter.
//   clk, rst_n  : clock, asynchronous active-low reset (flushes the FIFO)
//   push_i      : write wr_data_i at the clk edge (ignored while full)
//   wr_data_i   : data to write
//   pop_i       : drop the head entry at the clk edge (ignored while empty)
//   rd_data_o   : current head entry (valid while !empty_o)
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
module uart_tx_fifo_buf
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign rd_data_o = mem_q[rd_ptr_q];

    // Full blocks the write even if a pop happens on the same edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule : uart_tx_fifo_buf

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a write-side FIFO; frames go out LSB first and
// back-to-back while the FIFO has data.
//   clk, rst_n : clock, asynchronous active-low reset
//   trmt       : push tx_data into the FIFO (dropped and flagged while full)
//   tx_data    : byte to push
//   TX         : serial line, idles high
//   busy       : a frame is on the line
//   tx_done    : one-cycle pulse during the last cycle of each stop bit
//   full/empty : FIFO occupancy flags
//   ovf        : sticky, a push was attempted while full; cleared by reset
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = UART_BAUD_DIV,
    parameter int unsigned DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       busy,
    output logic       tx_done,
    output logic       full,
    output logic       empty,
    output logic       ovf
);

    localparam int unsigned   BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(UART_FRAME_BITS - 1);

    tx_state_t                    state_q;
    logic [BW-1:0]                baud_cnt_q;
    logic [3:0]                   bit_cnt_q;
    logic [UART_FRAME_BITS-1:0]   frame_q;
    logic [UART_FRAME_BITS-1:0]   frame_d;
    logic                         ovf_q;

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       pop;
    logic       baud_wrap;
    logic       frame_end;

    uart_tx_fifo_buf #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (trmt),
        .wr_data_i (tx_data),
        .pop_i     (pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign baud_wrap = (state_q == XMIT) && (baud_cnt_q == BAUD_LAST);
    assign frame_end = baud_wrap && (bit_cnt_q == BIT_LAST);

    // The head is popped either to start from idle or to chain straight
    // onto the end of the current stop bit.
    assign pop     = !fifo_empty && ((state_q == IDLE) || frame_end);
    assign frame_d = {1'b1, fifo_head, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        frame_q    <= frame_d;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= XMIT;
                    end
                end
                XMIT: begin
                    if (!baud_wrap) begin
                        baud_cnt_q <= baud_cnt_q + BW'(1);
                    end else begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            if (!fifo_empty) begin
                                frame_q <= frame_d;
                            end else begin
                                frame_q <= '1;
                                state_q <= IDLE;
                            end
                        end else begin
                            frame_q   <= {1'b1, frame_q[UART_FRAME_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (trmt && fifo_full) begin
            ovf_q <= 1'b1;
        end
    end

    // frame_q[0] is the line flop; it resets to 1 so TX idles high at once.
    assign TX      = frame_q[0];
    assign busy    = (state_q == XMIT);
    assign tx_done = frame_end;
    assign full    = fifo_full;
    assign empty   = fifo_empty;
    assign ovf     = ovf_q;

endmodule : uart_tx_fifo
